stall_ctrl: RTL

Issue-side hazard controller for the 5-stage pipeline: consumes the 2-bit pause code from the register file's collision tracker and holds PC/IF-ID or inserts an ID/EX bubble. Drives the collision address the register file shifts into its 3-deep in-flight destination buffer. Sits in the ID stage between the instruction decoder and the register file, closing the RAW-hazard loop. Keeps a stall-run watchdog and a saturating stall-cycle performance counter.

---
 rtl/stall_ctrl_pkg.sv | 21 ++
 rtl/stall_ctrl_sat_counter.sv | 34 +++
 rtl/stall_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared pause codes, FSM encodings and constants for the hazard controller
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE_NO   = 2'b00,
    PAUSE_RS   = 2'b01,
    PAUSE_RT   = 2'b10,
    PAUSE_BOTH = 2'b11
  } pause_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [31:0] INIT_32 = 32'h0000_0000;

  // Two bits cover a run of MAX_RUN=3; the third bit is headroom for the watchdog compare.
  localparam int RUN_CNT_W = 3;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// rtl/stall_ctrl_sat_counter.sv - W-bit up counter with clear that sticks at all-ones
module stall_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - ID-stage RAW hazard controller: hold/bubble issue, collision address,
// stall-run watchdog and saturating stall-cycle counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MAX_RUN = 3,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       pause_i,
  input  logic             id_valid_i,
  input  logic             uses_rs_i,
  input  logic             uses_rt_i,
  input  logic             dest_we_i,
  input  logic [4:0]       dest_addr_i,
  input  logic             flush_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             idex_bubble_o,
  output logic [4:0]       collision_addr_o,
  output logic             stall_active_o,
  output logic             hazard_err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [RUN_CNT_W-1:0] MAX_RUN_C = RUN_CNT_W'(MAX_RUN);

  logic                 live;
  logic                 hz;
  state_e               state_q;
  logic [RUN_CNT_W-1:0] run_cnt_q;
  logic                 hazard_err_q;

  // A flushed or bubbled slot is not a live instruction, so it neither stalls nor issues.
  assign live = rst_ni & id_valid_i & ~flush_i;
  assign hz   = live & ((pause_i[0] & uses_rs_i) | (pause_i[1] & uses_rt_i));

  assign pc_hold_o     = hz;
  assign ifid_hold_o   = hz;
  assign idex_bubble_o = hz;

  assign collision_addr_o = (live && !hz && dest_we_i && (dest_addr_i != 5'd0)) ? dest_addr_i : 5'd0;

  // run_cnt counts consecutive hz cycles; a run longer than the collision buffer is a tracker bug.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      run_cnt_q    <= '0;
      hazard_err_q <= 1'b0;
    end else if (!hz) begin
      state_q   <= ST_RUN;
      run_cnt_q <= '0;
    end else begin
      state_q <= ST_STALL;
      if (state_q == ST_RUN) begin
        run_cnt_q <= RUN_CNT_W'(1);
      end else if (run_cnt_q >= MAX_RUN_C) begin
        hazard_err_q <= 1'b1;
      end else begin
        run_cnt_q <= run_cnt_q + RUN_CNT_W'(1);
      end
    end
  end

  assign stall_active_o = (state_q == ST_STALL);
  assign hazard_err_o   = hazard_err_q;

  stall_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (1'b0),
    .inc_i   (hz),
    .count_o (stall_cycles_o)
  );

endmodule
